// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - round-robin arbiter sharing one 4x4 multiplier among N requesters
// Optional MSA_ZERO_BYPASS_EN: zero-operand requests answer directly without visiting the multiplier.
module mult_share_arbiter #(
   parameter int N        = 4,
   parameter int MULT_LAT = 1,
   parameter int IDW      = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic [N-1:0]     req_valid,
   input  logic [4*N-1:0]   req_a,
   input  logic [4*N-1:0]   req_b,
   output logic [N-1:0]     req_ready,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [7:0]       resp_p,
   output logic [IDW-1:0]   resp_id,
   output logic [3:0]       mult_a,
   output logic [3:0]       mult_b,
   input  logic [7:0]       mult_p
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]     state;
   logic [2:0]     lat_cnt;
   logic [IDW-1:0] rr_last;
   logic [IDW-1:0] cur_id;
   logic [IDW-1:0] grant_id;
   logic           grant_any;
   logic           grant;
   logic [2*N-1:0] rot;
   logic [3:0]     sel_a;
   logic [3:0]     sel_b;
   int             sum;

   // Rotate the request vector so bit 0 is the requester just after rr_last.
   always_comb begin
      rot       = {req_valid, req_valid} >> ({1'b0, rr_last} + {{IDW{1'b0}}, 1'b1});
      grant_any = 1'b0;
      grant_id  = '0;
      sum       = 0;
      for (int j = 0; j < N; j++) begin
         if (!grant_any && rot[j]) begin
            grant_any = 1'b1;
            sum       = int'(rr_last) + 1 + j;
            if (sum >= N) sum = sum - N;
            grant_id  = IDW'(sum);
         end
      end
   end

   assign grant = (state == S_IDLE) && ena && grant_any;

   always_comb begin
      req_ready = '0;
      sel_a     = '0;
      sel_b     = '0;
      for (int i = 0; i < N; i++) begin
         if (grant_id == IDW'(i)) begin
            sel_a        = req_a[4*i +: 4];
            sel_b        = req_b[4*i +: 4];
            req_ready[i] = grant;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         lat_cnt    <= '0;
         rr_last    <= IDW'(N - 1);
         cur_id     <= '0;
         mult_a     <= '0;
         mult_b     <= '0;
         resp_valid <= 1'b0;
         resp_p     <= '0;
         resp_id    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (grant) begin
                  rr_last <= grant_id;
                  cur_id  <= grant_id;
`ifdef MSA_ZERO_BYPASS_EN
                  if (sel_a == 4'd0 || sel_b == 4'd0) begin
                     resp_p     <= '0;
                     resp_id    <= grant_id;
                     resp_valid <= 1'b1;
                     state      <= S_RESP;
                  end else begin
                     mult_a  <= sel_a;
                     mult_b  <= sel_b;
                     lat_cnt <= 3'(MULT_LAT);
                     state   <= S_BUSY;
                  end
`else
                  mult_a  <= sel_a;
                  mult_b  <= sel_b;
                  lat_cnt <= 3'(MULT_LAT);
                  state   <= S_BUSY;
`endif
               end
            end
            S_BUSY: begin
               if (lat_cnt != 3'd0) begin
                  lat_cnt <= lat_cnt - 3'd1;
               end else begin
                  resp_p     <= mult_p;
                  resp_id    <= cur_id;
                  resp_valid <= 1'b1;
                  state      <= S_RESP;
               end
            end
            S_RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  state      <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb/tb_mult_share_arbiter.sv - self-checking bench for mult_share_arbiter
module tb_mult_share_arbiter;
   localparam int N = 4;
   localparam int MULT_LAT = 1;
   localparam int IDW = 2;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           ena = 1'b0;
   logic [N-1:0]   req_valid = '0;
   logic [4*N-1:0] req_a = '0;
   logic [4*N-1:0] req_b = '0;
   logic [N-1:0]   req_ready;
   logic           resp_valid;
   logic           resp_ready = 1'b1;
   logic [7:0]     resp_p;
   logic [IDW-1:0] resp_id;
   logic [3:0]     mult_a;
   logic [3:0]     mult_b;
   logic [7:0]     mult_p = '0;

   mult_share_arbiter #(.N(N), .MULT_LAT(MULT_LAT), .IDW(IDW)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena),
      .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_p(resp_p), .resp_id(resp_id),
      .mult_a(mult_a), .mult_b(mult_b), .mult_p(mult_p)
   );

   always #5 clk = ~clk;

   // One-stage multiplier core, matching MULT_LAT=1.
   always @(posedge clk) mult_p <= {4'b0, mult_a} * {4'b0, mult_b};

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d cycle=%0d", name, act, exp, cyc);
      end
   endtask

   // Transaction-level reference: one outstanding multiply, due at a known cycle.
   bit m_free = 1'b1;
   bit m_pend = 1'b0;
   bit m_byp = 1'b0;
   int m_rr = N - 1;
   int m_a, m_b, m_p, m_id, m_due;
   int g;
   bit exp_rv;
   logic [N-1:0] exp_rdy;
   int grant_log[$];
   int resp_log_p[$];
   int resp_log_id[$];

   always @(negedge clk) begin
      if (!rst_n) begin
         m_free = 1'b1;
         m_pend = 1'b0;
         m_rr   = N - 1;
      end else begin
         g = -1;
         if (m_free && ena)
            for (int k = 1; k <= N; k++)
               for (int j = 0; j < N; j++)
                  if (g < 0 && j == (m_rr + k) % N && req_valid[j]) g = j;
         exp_rdy = '0;
         for (int j = 0; j < N; j++) if (j == g) exp_rdy[j] = 1'b1;
         chk("req_ready", 32'(req_ready), 32'(exp_rdy));
         exp_rv = m_pend && (cyc >= m_due);
         chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
         if (exp_rv) begin
            chk("resp_p", 32'(resp_p), 32'(m_p));
            chk("resp_id", 32'(resp_id), 32'(m_id));
         end
         if (m_pend && !m_byp) begin
            chk("mult_a", 32'(mult_a), 32'(m_a));
            chk("mult_b", 32'(mult_b), 32'(m_b));
         end
         for (int j = 0; j < N; j++) if (req_ready[j]) grant_log.push_back(j);
         if (resp_valid && resp_ready) begin
            resp_log_p.push_back(int'(resp_p));
            resp_log_id.push_back(int'(resp_id));
         end
         if (exp_rv && resp_ready) begin
            m_pend = 1'b0;
            m_free = 1'b1;
         end
         if (g >= 0) begin
            for (int j = 0; j < N; j++)
               if (j == g) begin
                  m_a = int'(req_a[4*j +: 4]);
                  m_b = int'(req_b[4*j +: 4]);
               end
            m_p    = m_a * m_b;
            m_id   = g;
            m_rr   = g;
            m_due  = cyc + 2 + MULT_LAT;
            m_byp  = 1'b0;
`ifdef MSA_ZERO_BYPASS_EN
            if (m_a == 0 || m_b == 0) begin
               m_p   = 0;
               m_due = cyc + 1;
               m_byp = 1'b1;
            end
`endif
            m_pend = 1'b1;
            m_free = 1'b0;
         end
      end
      cyc++;
   end

   task automatic step(input logic [N-1:0] hold);
      logic [N-1:0] acc;
      @(negedge clk);
      acc = req_ready & req_valid;
      @(posedge clk); #1;
      req_valid = (req_valid & ~acc) | hold;
   endtask

   task automatic set_req(input int i, input int a, input int b);
      for (int j = 0; j < N; j++)
         if (j == i) begin
            req_valid[j]     = 1'b1;
            req_a[4*j +: 4] = 4'(a);
            req_b[4*j +: 4] = 4'(b);
         end
   endtask

   task automatic wait_resp(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!resp_valid && n < 40);
      if (!resp_valid) chk("resp_timeout", 32'(0), 32'(1));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_valid = '0;
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b1;
   endtask

   task automatic clear_logs();
      grant_log.delete();
      resp_log_p.delete();
      resp_log_id.delete();
   endtask

   int lat;
   logic [N-1:0] racc;

   initial begin
      do_reset();
      ena = 1'b1;
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'(0));
      chk("rst_resp_valid", 32'(resp_valid), 32'(0));
      chk("rst_resp_p", 32'(resp_p), 32'(0));
      chk("rst_resp_id", 32'(resp_id), 32'(0));
      chk("rst_mult_a", 32'(mult_a), 32'(0));
      chk("rst_mult_b", 32'(mult_b), 32'(0));
      @(posedge clk); #1;

      // Single request: 7*9.
      set_req(0, 7, 9);
      @(negedge clk);
      chk("single_ready", 32'(req_ready), 32'(4'b0001));
      @(posedge clk); #1;
      req_valid = '0;
      wait_resp(lat);
      chk("single_latency", 32'(lat), 32'(3));
      chk("single_p", 32'(resp_p), 32'(63));
      chk("single_id", 32'(resp_id), 32'(0));
      @(posedge clk); #1;

      // All four at once after reset.
      do_reset();
      clear_logs();
      set_req(0, 3, 5); set_req(1, 15, 15); set_req(2, 2, 8); set_req(3, 9, 1);
      repeat (20) step('0);
      chk("all4_ngrants", 32'(grant_log.size()), 32'(4));
      chk("all4_nresp", 32'(resp_log_p.size()), 32'(4));
      for (int i = 0; i < 4; i++) chk("all4_grant", 32'(grant_log[i]), 32'(i));
      chk("all4_p0", 32'(resp_log_p[0]), 32'(15));
      chk("all4_p1", 32'(resp_log_p[1]), 32'(225));
      chk("all4_p2", 32'(resp_log_p[2]), 32'(16));
      chk("all4_p3", 32'(resp_log_p[3]), 32'(9));
      for (int i = 0; i < 4; i++) chk("all4_id", 32'(resp_log_id[i]), 32'(i));

      // Round-robin wrap with req1 and req3 held.
      clear_logs();
      set_req(1, 4, 4); set_req(3, 5, 5);
      repeat (12) step(4'b1010);
      req_valid = '0;
      repeat (8) step('0);
      chk("rr_ngrants", 32'(grant_log.size()), 32'(3));
      chk("rr_g0", 32'(grant_log[0]), 32'(1));
      chk("rr_g1", 32'(grant_log[1]), 32'(3));
      chk("rr_g2", 32'(grant_log[2]), 32'(1));

      // Backpressure in RESP.
      clear_logs();
      set_req(2, 6, 7);
      step('0);
      set_req(0, 2, 5);
      resp_ready = 1'b0;
      wait_resp(lat);
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 32'(resp_valid), 32'(1));
         chk("bp_p", 32'(resp_p), 32'(42));
         chk("bp_id", 32'(resp_id), 32'(2));
         chk("bp_ready", 32'(req_ready), 32'(0));
         @(posedge clk); #1;
         @(negedge clk);
      end
      @(posedge clk); #1;
      resp_ready = 1'b1;
      repeat (8) step('0);
      chk("bp_nresp", 32'(resp_log_p.size()), 32'(2));
      chk("bp_p_first", 32'(resp_log_p[0]), 32'(42));
      chk("bp_p_second", 32'(resp_log_p[1]), 32'(10));

      // Enable gating.
      ena = 1'b0;
      set_req(2, 3, 4);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("ena_blocked", 32'(req_ready), 32'(0));
         @(posedge clk); #1;
      end
      ena = 1'b1;
      @(negedge clk);
      chk("ena_grant", 32'(req_ready), 32'(4'b0100));
      @(posedge clk); #1;
      req_valid = '0;
      ena = 1'b0;
      wait_resp(lat);
      chk("ena_p", 32'(resp_p), 32'(12));
      chk("ena_id", 32'(resp_id), 32'(2));
      @(posedge clk); #1;
      ena = 1'b1;
      repeat (4) step('0);

      // Reset mid-BUSY aborts the multiply.
      set_req(0, 15, 15);
      @(negedge clk);
      chk("abort_grant", 32'(req_ready), 32'(4'b0001));
      @(posedge clk); #1;
      req_valid = '0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_mult_a", 32'(mult_a), 32'(0));
      chk("abort_mult_b", 32'(mult_b), 32'(0));
      chk("abort_resp_p", 32'(resp_p), 32'(0));
      for (int i = 0; i < 5; i++) begin
         chk("abort_no_resp", 32'(resp_valid), 32'(0));
         @(negedge clk);
      end
      @(posedge clk); #1;
      set_req(0, 1, 1);
      @(negedge clk);
      chk("post_abort_grant", 32'(req_ready), 32'(4'b0001));
      @(posedge clk); #1;
      req_valid = '0;
      wait_resp(lat);
      chk("post_abort_latency", 32'(lat), 32'(3));
      chk("post_abort_p", 32'(resp_p), 32'(1));
      @(posedge clk); #1;

`ifdef MSA_ZERO_BYPASS_EN
      set_req(0, 0, 12);
      @(negedge clk);
      @(posedge clk); #1;
      req_valid = '0;
      wait_resp(lat);
      chk("bypass_latency", 32'(lat), 32'(1));
      chk("bypass_p", 32'(resp_p), 32'(0));
      @(posedge clk); #1;
`endif

      // Randomized traffic with backpressure, enable toggling and dropped requests.
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         racc = req_ready & req_valid;
         @(posedge clk); #1;
         req_valid = req_valid & ~racc;
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && $urandom_range(3) == 0) begin
               req_valid[i]     = 1'b1;
               req_a[4*i +: 4] = 4'($urandom);
               req_b[4*i +: 4] = 4'($urandom);
            end else if (req_valid[i] && $urandom_range(31) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
         ena = ($urandom_range(9) != 0);
         resp_ready = ($urandom_range(9) < 7);
      end
      req_valid = '0;
      ena = 1'b1;
      resp_ready = 1'b1;
      repeat (10) step('0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one 4x4 unsigned array multiplier (operands a, b; product p) among N requesters.
- Arbitrates with round-robin priority and sequences one multiply at a time.
- Waits a configurable number of cycles for the multiplier result, then returns the 8-bit product with the requester ID.
- Sits between client logic and the multiplier core inside the top-level user project.

Parameters:
- N, 4, number of requesters (2..8).
- MULT_LAT, 1, extra clock cycles of multiplier latency (0 = combinational core, max 7).
- IDW, 2, requester ID width; must be >= clog2(N).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- ena  in  1  design enable; low blocks new grants.
- req_valid  in  N  per-requester request strobe.
- req_a  in  4*N  operand A; requester i uses bits [4i+3:4i].
- req_b  in  4*N  operand B; same packing as req_a.
- req_ready  out  N  one-hot accept pulse; request i is consumed on a cycle where req_valid[i] and req_ready[i] are both high.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_p  out  8  product a*b.
- resp_id  out  IDW  index of the requester that owns resp_p.
- mult_a  out  4  operand to the multiplier core.
- mult_b  out  4  operand to the multiplier core.
- mult_p  in  8  product from the multiplier core.

Behaviour:
- Reset (rst_n low at an edge):
  - req_ready, resp_valid, resp_p, resp_id, mult_a and mult_b all go to 0.
  - State goes to IDLE; lat_cnt = 0.
  - Round-robin pointer rr_last = N-1, so requester 0 has top priority first.
  - Reset mid-operation aborts the in-flight multiply; no response is produced.
- State machine: IDLE -> BUSY -> RESP -> IDLE.
- IDLE:
  - If ena=1 and any req_valid is high, grant g = first set bit searching rr_last+1, rr_last+2, ... with modulo-N wrap.
  - req_ready[g] is high combinationally in that cycle (cycle T); no other req_ready bit is high.
  - At the edge ending cycle T: latch mult_a/mult_b from requester g, latch id=g, set rr_last=g, set lat_cnt=MULT_LAT, go to BUSY.
  - If ena=0 or no request is valid: req_ready=0 and the state stays IDLE.
- BUSY:
  - mult_a/mult_b are held stable.
  - If lat_cnt != 0: decrement lat_cnt.
  - If lat_cnt == 0: register resp_p=mult_p and resp_id=id, go to RESP.
  - req_ready=0 throughout BUSY.
- RESP:
  - resp_valid=1; resp_p and resp_id are held stable.
  - If resp_ready=1, clear resp_valid and go to IDLE at that edge.
  - Backpressure holds RESP indefinitely.
- Latency: accept in cycle T -> resp_valid first high in cycle T+2+MULT_LAT.
- Throughput: one multiply per 3+MULT_LAT cycles when resp_ready is tied high.
- ena deasserted in BUSY or RESP: the in-flight operation completes normally; only new grants are blocked.
- A request dropped (req_valid low) before it is granted is never issued.
- Simultaneous requests are serviced fairly; a continuously asserting requester cannot starve another.
- Arithmetic is unsigned; the 4x4 -> 8-bit product cannot overflow.

Optional Feature:
- Macro: MSA_ZERO_BYPASS_EN.
- Defined:
  - In IDLE, if the granted request has a==0 or b==0, skip BUSY and go straight to RESP with resp_p=0.
  - Latency for that request is resp_valid in cycle T+1.
  - mult_a/mult_b keep their previous values.
- Undefined: every request passes through BUSY, including zero operands.

Test Plan (N=4, MULT_LAT=1, resp_ready=1 unless stated):
- Reset then single request: req0 a=7 b=9 at cycle T -> req_ready=4'b0001 at T; resp_valid at T+3 with resp_p=63, resp_id=0.
- All four requesters valid at once with distinct operands (3x5, 15x15, 2x8, 9x1) -> grants in order 0,1,2,3; responses 15, 225, 16, 9 with IDs 0..3.
- Round-robin wrap: after a grant to 3, hold req3 and req1 valid -> the next grant goes to 1, then 3; req3 is never granted twice in a row.
- Backpressure: resp_ready=0 for 5 cycles during RESP -> resp_valid, resp_p and resp_id stay constant, req_ready stays 0, and no new grant occurs until resp_ready=1.
- ena=0 while req2 is valid -> no req_ready for 10 cycles. Then raise ena -> grant to 2. Drop ena during BUSY -> response still delivered.
- Reset mid-BUSY with a=15 b=15 -> resp_valid stays 0, all outputs 0. A subsequent req0 a=1 b=1 returns resp_p=1 with normal latency. With MSA_ZERO_BYPASS_EN: a=0 b=12 -> resp_valid at T+1 with resp_p=0.
